// File: rtl/sync_fifo_param_if.sv
// Handshake/data bundle between a FIFO producer/consumer and sync_fifo_param.
interface sync_fifo_param_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
);
  logic                  push;
  logic                  pop;
  logic                  err_clear;
  logic [DATA_WIDTH-1:0] din;
  logic [DATA_WIDTH-1:0] dout;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  // User side: drives push/pop/data, observes status.
  modport master (
    output push, pop, err_clear, din,
    input  dout, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  // FIFO side.
  modport slave (
    input  push, pop, err_clear, din,
    output dout, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised synchronous FIFO with first-word-fall-through read port,
// occupancy count, almost-full/empty flags and sticky misuse flags.
module sync_fifo_param #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 3,
  parameter int AFULL_LEVEL  = 6,
  parameter int AEMPTY_LEVEL = 1
) (
  input  logic              clk,
  input  logic              reset,
  sync_fifo_param_if.slave  f
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] PTR_ONE    = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] AFULL_CNT  = (ADDR_WIDTH+1)'(AFULL_LEVEL);
  localparam logic [ADDR_WIDTH:0] AEMPTY_CNT = (ADDR_WIDTH+1)'(AEMPTY_LEVEL);

  // Storage is deliberately not reset; dout of an empty FIFO is stale data.
  logic [DATA_WIDTH-1:0] mem_reg [DEPTH];

  logic [ADDR_WIDTH:0]   wr_ptr_reg, wr_ptr_next;
  logic [ADDR_WIDTH:0]   rd_ptr_reg, rd_ptr_next;
  logic                  overflow_reg, overflow_next;
  logic                  underflow_reg, underflow_next;
  logic [ADDR_WIDTH:0]   count_w;
  logic                  full_w, empty_w;
  logic                  push_ok, pop_ok;
  logic [DEPTH-1:0]      wr_en;
  logic [ADDR_WIDTH-1:0] wr_idx, rd_idx;

  assign wr_idx  = wr_ptr_reg[ADDR_WIDTH-1:0];
  assign rd_idx  = rd_ptr_reg[ADDR_WIDTH-1:0];

  // Status is a pure decode of the pointers, so it only moves after an edge.
  assign count_w = wr_ptr_reg - rd_ptr_reg;
  assign empty_w = (wr_ptr_reg == rd_ptr_reg);
  assign full_w  = (wr_idx == rd_idx) && (wr_ptr_reg[ADDR_WIDTH] != rd_ptr_reg[ADDR_WIDTH]);

  // A pop frees the head slot, so a push into a full FIFO is fine when paired with one.
  assign pop_ok  = f.pop && !empty_w;
  assign push_ok = f.push && (!full_w || pop_ok);

  // One write strobe per storage entry; reset blocks the write along with everything else.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
    assign wr_en[gi] = push_ok && !reset && (wr_idx == ADDR_WIDTH'(gi));
  end

  // Storage write: only the addressed entry captures din.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_en[i]) mem_reg[i] <= f.din;
    end
  end

  // Next pointers and sticky flags; a fresh rejection overrides err_clear.
  always_comb begin
    wr_ptr_next    = wr_ptr_reg;
    rd_ptr_next    = rd_ptr_reg;
    overflow_next  = overflow_reg;
    underflow_next = underflow_reg;
    if (push_ok) wr_ptr_next = wr_ptr_reg + PTR_ONE;
    if (pop_ok)  rd_ptr_next = rd_ptr_reg + PTR_ONE;
    if (f.err_clear) begin
      overflow_next  = 1'b0;
      underflow_next = 1'b0;
    end
    if (f.push && !push_ok) overflow_next  = 1'b1;
    if (f.pop  && !pop_ok)  underflow_next = 1'b1;
  end

  // State register with synchronous reset dominating all inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  assign f.dout         = mem_reg[rd_idx];
  assign f.count        = count_w;
  assign f.full         = full_w;
  assign f.empty        = empty_w;
  assign f.almost_full  = (count_w >= AFULL_CNT);
  assign f.almost_empty = (count_w <= AEMPTY_CNT);
  assign f.overflow     = overflow_reg;
  assign f.underflow    = underflow_reg;
endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised synchronous FIFO, the general-purpose successor to the fixed 8×8 byte queue used between the host link and the programmer sequencers. It has configurable data width and power-of-two depth, and a first-word-fall-through read port. It adds an occupancy count, programmable almost-full and almost-empty flags, and sticky overflow/underflow error flags. Misuse of the FIFO (push when full, pop when empty) is blocked by the FIFO itself, so upstream logic can rely on the error flags rather than on its own guarding.

## Interface
- DATA_WIDTH, 8, width of din/dout in bits (≥1)
- ADDR_WIDTH, 3, log2 of depth; DEPTH = 2^ADDR_WIDTH (≥1)
- AFULL_LEVEL, 6, almost_full asserts when count ≥ AFULL_LEVEL (1..DEPTH)
- AEMPTY_LEVEL, 1, almost_empty asserts when count ≤ AEMPTY_LEVEL (0..DEPTH-1)

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- push  in  1  write din this cycle
- pop  in  1  consume dout this cycle
- din  in  DATA_WIDTH  write data
- dout  out  DATA_WIDTH  head-of-queue data, combinational from storage at read pointer
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AFULL_LEVEL
- almost_empty  out  1  count ≤ AEMPTY_LEVEL
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: a push was rejected
- underflow  out  1  sticky: a pop was rejected
- err_clear  in  1  clears overflow and underflow

## Operation
- Storage: DEPTH × DATA_WIDTH register array. It is not reset.
- Pointers: read and write pointers, each ADDR_WIDTH+1 bits. The MSB is the wrap bit.
  - count = write pointer − read pointer, modulo 2^(ADDR_WIDTH+1).
  - full: indices are equal and wrap bits differ.
  - empty: pointers are identical.
- Push is accepted when push=1 and (not full, or pop is accepted in the same cycle).
  - On acceptance, din is written at write index and the write pointer increments.
- Pop is accepted when pop=1 and not empty. The read pointer increments.
- Push rejected (push=1 while full and no accepted pop): storage and pointers are unchanged; overflow is set.
- Pop rejected (pop=1 while empty): pointers are unchanged; underflow is set.
- Simultaneous push+pop:
  - Not empty and not full: both accepted; count unchanged.
  - Full: both accepted; count stays DEPTH; the head entry is consumed and din lands in the freed slot.
  - Empty: push accepted, pop rejected; count becomes 1; underflow is set.
- Pointers wrap naturally at 2^(ADDR_WIDTH+1) with no special handling.
- err_clear clears both sticky flags. If a new rejection occurs in the same cycle, the corresponding flag is set (set wins).
- dout is valid only while empty=0. While empty, dout shows the stale storage word at the read index.

## Timing
- Reset (synchronous, dominates all inputs including push/pop/err_clear), values on the next edge:
  - pointers 0, count 0, empty 1, full 0
  - almost_empty 1, almost_full 0
  - overflow 0, underflow 0
- Write-to-read latency:
  - A word pushed at edge N is visible on dout and counted after edge N.
  - If the FIFO was empty, empty deasserts after edge N.
  - A pop in cycle N+1 consumes it.
- Pop: dout advances to the next entry after the edge on which the pop is accepted. dout is sampled by the consumer in the same cycle that pop is asserted.
- full, empty, almost_full, almost_empty and count are combinational decodes of the pointers. All of them change only after a clock edge.
- overflow and underflow rise on the edge following the offending cycle and remain high until err_clear or reset.

## Test plan
All scenarios use the defaults (DATA_WIDTH=8, ADDR_WIDTH=3, AFULL=6, AEMPTY=1).
- Reset, then push 0x11..0x88 on 8 consecutive cycles:
  - count steps 1..8.
  - almost_empty drops when count reaches 2; almost_full rises when count reaches 6.
  - full=1 after the 8th push.
  - dout=0x11 throughout.
- From full, pop 8 cycles:
  - dout reads 0x11,0x22,…,0x88 in order.
  - empty=1 and count=0 at the end; no error flags.
- Push 0x99 while full without pop:
  - count stays 8; overflow=1.
  - Subsequent pops return 0x11..0x88 (0x99 discarded).
- Pop when empty with push 0xA5 in the same cycle:
  - count=1, dout=0xA5, underflow=1.
  - err_clear for one cycle gives underflow=0.
- While full, push+pop for 20 consecutive cycles with din incrementing from 0x00:
  - count stays 8 and pointers wrap repeatedly.
  - Popped sequence continues 0x11..0x88 then 0x00, 0x01, … with no loss.
- Assert reset mid-stream with count=5 and push=pop=1:
  - Next cycle count=0, empty=1, flags cleared.
  - The next push of 0x3C appears on dout.
